// File: rtl/vram2_tile_fetcher.sv
// Per-scanline name-table fetcher for VRAM2: reads code/attr byte pairs into a 2-entry tile FIFO.
// Optional macro VRAM2_FETCH_VFLIP_EN: attr[7] flips the pixel row within the tile.
module vram2_tile_fetcher #(
  parameter int unsigned TILES_PER_LINE = 33,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_LINE_START,
  input  logic [7:0]  i_VLINE,
  input  logic [7:0]  i_VSCROLL,
  input  logic [8:0]  i_HSCROLL,
  input  logic        i_CPU_BUSY,
  output logic [11:0] o_VRAM_ADDR,
  output logic        o_VRAM_RD_n,
  input  logic [7:0]  i_VRAM_DOUT,
  output logic        o_TILE_VALID,
  input  logic        i_TILE_READY,
  output logic [9:0]  o_TILE_CODE,
  output logic [3:0]  o_TILE_PAL,
  output logic        o_TILE_HFLIP,
  output logic [2:0]  o_TILE_ROW,
  output logic        o_LINE_DONE
);

  typedef enum logic [2:0] {StIdle, StRdCode, StRdAttr, StCapture, StWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  y_q;
  logic [5:0]  col_q;
  logic [5:0]  cnt_q;
  logic [7:0]  code_q;
  logic        code_got_q;
  logic [7:0]  attr_q;
  logic        line_done_q;
  logic [17:0] fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;

  logic        granted, pop, full, push, last;
  logic [7:0]  attr_cur;
  logic [2:0]  row;
  logic [17:0] push_data;
  logic [17:0] head;

  assign granted     = ((state_q == StRdCode) || (state_q == StRdAttr)) && !i_CPU_BUSY;
  assign o_VRAM_RD_n = !granted;
  assign o_VRAM_ADDR = {y_q[7:3], 6'(col_q + cnt_q), (state_q == StRdAttr)};

  assign pop  = (count_q != 2'd0) && i_TILE_READY;
  assign full = (count_q == 2'(FIFO_DEPTH));
  assign last = (cnt_q == 6'(TILES_PER_LINE - 1));
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign push = ((state_q == StCapture) || (state_q == StWait)) && (!full || pop);

  // Attr arrives on the SRAM bus during CAPTURE; later pushes use the latched copy.
  assign attr_cur = (state_q == StCapture) ? i_VRAM_DOUT : attr_q;

`ifdef VRAM2_FETCH_VFLIP_EN
  assign row = attr_cur[7] ? ~y_q[2:0] : y_q[2:0];
  logic unused_bits;
  assign unused_bits = ^i_HSCROLL[2:0];
`else
  assign row = y_q[2:0];
  logic unused_bits;
  assign unused_bits = ^{i_HSCROLL[2:0], attr_cur[7]};
`endif

  assign push_data = {attr_cur[1:0], code_q, attr_cur[5:2], attr_cur[6], row};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StIdle;
      StRdCode: if (granted) state_d = StRdAttr;
      StRdAttr: if (granted) state_d = StCapture;
      StCapture, StWait: begin
        if (push) state_d = last ? StIdle : StRdCode;
        else      state_d = StWait;
      end
      default:  state_d = StIdle;
    endcase
    if (i_LINE_START) state_d = StRdCode;
  end

  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state_q     <= StIdle;
      y_q         <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      code_got_q  <= 1'b0;
      attr_q      <= '0;
      line_done_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (i_LINE_START) begin
        y_q         <= 8'(i_VLINE + i_VSCROLL);
        col_q       <= i_HSCROLL[8:3];
        cnt_q       <= '0;
        code_got_q  <= 1'b0;
        line_done_q <= 1'b0;
        wr_ptr_q    <= 1'b0;
        rd_ptr_q    <= 1'b0;
        count_q     <= '0;
      end else begin
        line_done_q <= push && last;
        if (state_q == StRdCode) code_got_q <= 1'b0;
        // Only the first RD_ATTR cycle sees the code byte; CPU reads may overwrite DOUT later.
        if ((state_q == StRdAttr) && !code_got_q) begin
          code_q     <= i_VRAM_DOUT;
          code_got_q <= 1'b1;
        end
        if (state_q == StCapture) attr_q <= i_VRAM_DOUT;
        if (push) begin
          fifo_q[wr_ptr_q] <= push_data;
          wr_ptr_q         <= !wr_ptr_q;
          cnt_q            <= cnt_q + 6'd1;
        end
        if (pop) rd_ptr_q <= !rd_ptr_q;
        count_q <= 2'(count_q + {1'b0, push} - {1'b0, pop});
      end
    end
  end

  assign head         = fifo_q[rd_ptr_q];
  assign o_TILE_VALID = (count_q != 2'd0);
  assign o_TILE_CODE  = head[17:8];
  assign o_TILE_PAL   = head[7:4];
  assign o_TILE_HFLIP = head[3];
  assign o_TILE_ROW   = head[2:0];
  assign o_LINE_DONE  = line_done_q;

endmodule

// File: tb/tb_vram2_tile_fetcher.sv
// Randomized bench for vram2_tile_fetcher: SRAM model plus a per-line model of the
// expected read addresses and tile stream.
module tb_vram2_tile_fetcher;

  logic        i_MCLK = 1'b0;
  logic        i_RST_n;
  logic        i_LINE_START;
  logic [7:0]  i_VLINE;
  logic [7:0]  i_VSCROLL;
  logic [8:0]  i_HSCROLL;
  logic        i_CPU_BUSY;
  logic [11:0] o_VRAM_ADDR;
  logic        o_VRAM_RD_n;
  logic [7:0]  i_VRAM_DOUT;
  logic        o_TILE_VALID;
  logic        i_TILE_READY;
  logic [9:0]  o_TILE_CODE;
  logic [3:0]  o_TILE_PAL;
  logic        o_TILE_HFLIP;
  logic [2:0]  o_TILE_ROW;
  logic        o_LINE_DONE;

  vram2_tile_fetcher dut (
    .i_MCLK       (i_MCLK),
    .i_RST_n      (i_RST_n),
    .i_LINE_START (i_LINE_START),
    .i_VLINE      (i_VLINE),
    .i_VSCROLL    (i_VSCROLL),
    .i_HSCROLL    (i_HSCROLL),
    .i_CPU_BUSY   (i_CPU_BUSY),
    .o_VRAM_ADDR  (o_VRAM_ADDR),
    .o_VRAM_RD_n  (o_VRAM_RD_n),
    .i_VRAM_DOUT  (i_VRAM_DOUT),
    .o_TILE_VALID (o_TILE_VALID),
    .i_TILE_READY (i_TILE_READY),
    .o_TILE_CODE  (o_TILE_CODE),
    .o_TILE_PAL   (o_TILE_PAL),
    .o_TILE_HFLIP (o_TILE_HFLIP),
    .o_TILE_ROW   (o_TILE_ROW),
    .o_LINE_DONE  (o_LINE_DONE)
  );

  always #5 i_MCLK = ~i_MCLK;

  logic [7:0]  vram [4096];
  logic [11:0] rd_q [$];
  logic [17:0] tile_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int line_reads, line_pops, line_dones;

  // Registered SRAM; CPU-owned cycles leave unrelated data on the bus.
  always @(posedge i_MCLK) begin
    if (!o_VRAM_RD_n)    i_VRAM_DOUT <= vram[o_VRAM_ADDR];
    else if (i_CPU_BUSY) i_VRAM_DOUT <= 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] tile_exp(input logic [7:0] c, input logic [7:0] a,
                                           input logic [7:0] y);
    logic [2:0] r;
    r = y[2:0];
`ifdef VRAM2_FETCH_VFLIP_EN
    if (a[7]) r = 3'd7 - y[2:0];
`endif
    return {a[1:0], c, a[5:2], a[6], r};
  endfunction

  task automatic build_model(input logic [7:0] vl, input logic [7:0] vs, input logic [8:0] hs);
    int y, col;
    logic [11:0] a;
    rd_q.delete();
    tile_q.delete();
    y = (int'(vl) + int'(vs)) % 256;
    for (int k = 0; k < 33; k++) begin
      col = (int'(hs) / 8 + k) % 64;
      a = 12'((y / 8) * 128 + col * 2);
      rd_q.push_back(a);
      rd_q.push_back(a + 12'd1);
      tile_q.push_back(tile_exp(vram[a], vram[a + 12'd1], 8'(y)));
    end
  endtask

  task automatic cycle(input logic ls, input logic busy, input logic rdy);
    @(negedge i_MCLK);
    i_LINE_START = ls;
    i_CPU_BUSY   = busy;
    i_TILE_READY = rdy;
    #1;
    if (busy) check("rdn_busy", 32'(o_VRAM_RD_n), 32'd1);
    if (!o_VRAM_RD_n) begin
      line_reads++;
      if (rd_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
      else check("rd_addr", 32'(o_VRAM_ADDR), 32'(rd_q.pop_front()));
    end
    if (o_TILE_VALID && rdy && !ls) begin
      line_pops++;
      if (tile_q.size() == 0) check("tile_extra", 32'd1, 32'd0);
      else check("tile", 32'({o_TILE_CODE, o_TILE_PAL, o_TILE_HFLIP, o_TILE_ROW}),
                 32'(tile_q.pop_front()));
    end
    if (o_LINE_DONE) line_dones++;
  endtask

  task automatic start_line(input logic [7:0] vl, input logic [7:0] vs, input logic [8:0] hs);
    i_VLINE   = vl;
    i_VSCROLL = vs;
    i_HSCROLL = hs;
    cycle(1'b1, 1'b0, 1'b0);
    line_reads = 0;
    line_pops  = 0;
    line_dones = 0;
    build_model(vl, vs, hs);
  endtask

  task automatic finish_line(input int busy_pct, input int rdy_pct);
    int guard = 0;
    while (tile_q.size() != 0 && guard < 3000) begin
      cycle(1'b0, ($urandom_range(99) < busy_pct), ($urandom_range(99) < rdy_pct));
      guard++;
    end
    check("line_timeout", 32'(guard < 3000), 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check("line_pops", 32'(line_pops), 32'd33);
    check("line_reads", 32'(line_reads), 32'd66);
    check("line_done", 32'(line_dones), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdn"}, 32'(o_VRAM_RD_n), 32'd1);
    check({tag, "_addr"}, 32'(o_VRAM_ADDR), 32'd0);
    check({tag, "_valid"}, 32'(o_TILE_VALID), 32'd0);
    check({tag, "_head"}, 32'({o_TILE_CODE, o_TILE_PAL, o_TILE_HFLIP, o_TILE_ROW}), 32'd0);
    check({tag, "_done"}, 32'(o_LINE_DONE), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) vram[i] = 8'($urandom);
    i_RST_n = 1'b0; i_LINE_START = 1'b0; i_CPU_BUSY = 1'b0; i_TILE_READY = 1'b0;
    i_VLINE = '0; i_VSCROLL = '0; i_HSCROLL = '0;
    repeat (2) @(negedge i_MCLK);
    i_RST_n = 1'b1;
    #1;
    check_reset_outputs("rst");

    // Known first tile and three-cycle latency.
    vram[0] = 8'h5A;
    vram[1] = 8'h87;
    start_line(8'd3, 8'd0, 9'd0);
    repeat (3) begin
      cycle(1'b0, 1'b0, 1'b0);
      check("lat_early", 32'(o_TILE_VALID), 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check("lat_valid", 32'(o_TILE_VALID), 32'd1);
    check("t1_code", 32'(o_TILE_CODE), 32'h35A);
    check("t1_pal", 32'(o_TILE_PAL), 32'd1);
    check("t1_hflip", 32'(o_TILE_HFLIP), 32'd0);
`ifdef VRAM2_FETCH_VFLIP_EN
    check("t1_row", 32'(o_TILE_ROW), 32'd4);
`else
    check("t1_row", 32'(o_TILE_ROW), 32'd3);
`endif
    finish_line(0, 100);

    // Column wrap 63 -> 0.
    start_line(8'd77, 8'd200, 9'h1F8);
    finish_line(0, 100);

    // CPU holds VRAM for 5 cycles during RD_ATTR.
    start_line(8'($urandom), 8'($urandom), 9'($urandom));
    cycle(1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0);
    finish_line(0, 100);

    // Backpressure: 2 buffered + 1 held in WAIT, then drain.
    start_line(8'($urandom), 8'($urandom), 9'($urandom));
    repeat (30) cycle(1'b0, 1'b0, 1'b0);
    check("bp_reads", 32'(line_reads), 32'd6);
    check("bp_rdn", 32'(o_VRAM_RD_n), 32'd1);
    check("bp_valid", 32'(o_TILE_VALID), 32'd1);
    finish_line(0, 100);

    // Mid-line restart at tile 10.
    start_line(8'($urandom), 8'($urandom), 9'($urandom));
    begin
      int guard = 0;
      while (line_pops < 10 && guard < 500) begin
        cycle(1'b0, 1'b0, 1'b1);
        guard++;
      end
      check("abort_timeout", 32'(guard < 500), 32'd1);
    end
    start_line(8'($urandom), 8'($urandom), 9'($urandom));
    cycle(1'b0, 1'b0, 1'b1);
    check("abort_flush", 32'(o_TILE_VALID), 32'd0);
    finish_line(0, 100);

    // Randomized lines with CPU contention and bursty consumer.
    repeat (6) begin
      start_line(8'($urandom), 8'($urandom), 9'($urandom));
      finish_line(25, 60);
    end

    // One-cycle reset mid-fetch.
    start_line(8'($urandom), 8'($urandom), 9'($urandom));
    repeat (8) cycle(1'b0, 1'b0, 1'b1);
    @(negedge i_MCLK);
    i_RST_n = 1'b0; i_LINE_START = 1'b0; i_CPU_BUSY = 1'b0; i_TILE_READY = 1'b0;
    @(negedge i_MCLK);
    i_RST_n = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    rd_q.delete();
    tile_q.delete();
    repeat (4) begin
      cycle(1'b0, 1'b0, 1'b1);
      check("post_rst_rdn", 32'(o_VRAM_RD_n), 32'd1);
      check("post_rst_valid", 32'(o_TILE_VALID), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
